// File: rtl/data_memory_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_access_unit_if
//  Purpose  : Bundles the MEM-stage request side and the data-memory
//             req/ack side of the data memory access unit.
//  Revision : 1.0  initial release
// ============================================================================
interface data_memory_access_unit_if;
    // pipeline (MEM stage) side
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] data_out;
    logic        busy_wait;
    logic        access_fault;
    // data memory side
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // view of the access unit itself
    modport master (
        input  mem_read, mem_write, func3, address, write_data, mem_rdata, mem_ack,
        output data_out, busy_wait, access_fault,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    // view of the surrounding pipeline + memory model
    modport slave (
        output mem_read, mem_write, func3, address, write_data, mem_rdata, mem_ack,
        input  data_out, busy_wait, access_fault,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_access_unit
//  Purpose  : MEM-stage bridge to a multi-cycle req/ack data memory. Latches
//             a load/store, drives word address, byte enables and replicated
//             store data, stalls the pipeline until acknowledge, returns the
//             offset-aligned read word, and drops/flags illegal, misaligned
//             or timed-out accesses.
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_access_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    data_memory_access_unit_if.master bus
);

    localparam int                 c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_offset;

    logic               w_req;
    logic               w_func3_ok;
    logic               w_misaligned;
    logic               w_fault;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_last;

    // Request decode: legality, alignment, byte lanes and replicated data
    always_comb begin
        w_req        = bus.mem_read | bus.mem_write;
        w_func3_ok   = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = bus.write_data;

        if (bus.mem_write)
            w_func3_ok = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) ||
                         (bus.func3 == 3'b010);
        else
            w_func3_ok = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) ||
                         (bus.func3 == 3'b010) || (bus.func3 == 3'b100) ||
                         (bus.func3 == 3'b101);

        // func3[1:0] encodes the access size for both signed and unsigned loads
        case (bus.func3[1:0])
            2'b01:   w_misaligned = bus.address[0];
            2'b10:   w_misaligned = (bus.address[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase

        w_fault = (bus.mem_read & bus.mem_write) | ~w_func3_ok | w_misaligned;

        case (bus.func3[1:0])
            2'b00: begin
                w_wdata = {4{bus.write_data[7:0]}};
                if (bus.mem_write) w_be = 4'b0001 << bus.address[1:0];
            end
            2'b01: begin
                w_wdata = {2{bus.write_data[15:0]}};
                if (bus.mem_write) w_be = 4'b0011 << bus.address[1:0];
            end
            default: begin
                w_wdata = bus.write_data;
                w_be    = 4'b1111;
            end
        endcase

        w_last = (r_count == c_CNT_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; ACK beats a coincident timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_req) w_next_state = w_fault ? c_ST_DONE : c_ST_ACCESS;
            c_ST_ACCESS: if (bus.mem_ack || w_last) w_next_state = c_ST_DONE;
            c_ST_DONE:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // Pipeline stall: raised as soon as a request appears, dropped in DONE
    always_comb begin
        bus.busy_wait = ((r_state == c_ST_IDLE) & w_req) | (r_state == c_ST_ACCESS);
    end

    // Memory-side registers, wait counter, fault pulse and load data return
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out     <= '0;
            bus.access_fault <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_be       <= '0;
            bus.mem_wdata    <= '0;
            r_count          <= '0;
            r_offset         <= '0;
        end else begin
            bus.access_fault <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_count <= '0;
                    if (w_req) begin
                        if (w_fault) begin
                            bus.access_fault <= 1'b1;
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.mem_write;
                            bus.mem_addr  <= bus.address[31:2];
                            bus.mem_be    <= w_be;
                            bus.mem_wdata <= w_wdata;
                            r_offset      <= bus.address[1:0];
                        end
                    end
                end
                c_ST_ACCESS: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        if (!bus.mem_we)
                            bus.data_out <= bus.mem_rdata >> {r_offset, 3'b000};
                    end else if (w_last) begin
                        bus.mem_req      <= 1'b0;
                        bus.access_fault <= 1'b1;
                        if (!bus.mem_we)
                            bus.data_out <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_count <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_access_unit
//  Purpose  : Self-checking bench for data_memory_access_unit (TIMEOUT = 4)
//             using directed scenarios plus randomized transactions checked
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_memory_access_unit;

    localparam int TIMEOUT = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] model_dout;

    data_memory_access_unit_if bus ();

    data_memory_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One MEM-stage transaction. ack_at = access cycle (1-based) carrying the ACK,
    // 0 or > TIMEOUT means the memory never answers.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, input int ack_at, input string tag);
        int          size;
        int          off;
        bit          legal;
        bit          fault;
        bit          to;
        int          n_acc;
        logic [3:0]  e_be;
        logic [31:0] e_wd;

        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr % 4);
        legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        fault = (rd && wr) || !legal || ((addr % size) != 0);
        e_be  = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
        e_wd  = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        to    = (ack_at < 1) || (ack_at > TIMEOUT);
        n_acc = to ? TIMEOUT : ack_at;

        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.func3      = f3;
        bus.address    = addr;
        bus.write_data = wd;
        bus.mem_rdata  = rword;
        bus.mem_ack    = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy_wait, bus.mem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s idle-accept: busy/req=%b required 10", tag, {bus.busy_wait, bus.mem_req});
        end
        @(posedge clk); #1;

        if (!fault) begin
            for (int k = 1; k <= n_acc; k++) begin
                bus.mem_ack = (k == ack_at);
                #1;
                n_checks++;
                if ({bus.mem_req, bus.busy_wait, bus.access_fault} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL %s access%0d ctl: req/busy/fault=%b required 110",
                             tag, k, {bus.mem_req, bus.busy_wait, bus.access_fault});
                end
                n_checks++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_be} !== {wr, addr[31:2], e_be}) begin
                    n_fail++;
                    $display("FAIL %s access%0d bus: we=%b addr=%h be=%b required we=%b addr=%h be=%b",
                             tag, k, bus.mem_we, bus.mem_addr, bus.mem_be, wr, addr[31:2], e_be);
                end
                if (wr) begin
                    n_checks++;
                    if (bus.mem_wdata !== e_wd) begin
                        n_fail++;
                        $display("FAIL %s access%0d wdata: got %h required %h", tag, k, bus.mem_wdata, e_wd);
                    end
                end
                @(posedge clk); #1;
            end
            bus.mem_ack = 1'b0;
            if (rd) model_dout = to ? 32'h0 : (rword >> (8 * off));
        end

        // DONE cycle
        n_checks++;
        if ({bus.busy_wait, bus.mem_req, bus.access_fault} !== {2'b00, (fault || to)}) begin
            n_fail++;
            $display("FAIL %s done ctl: busy/req/fault=%b required 00%b",
                     tag, {bus.busy_wait, bus.mem_req, bus.access_fault}, (fault || to));
        end
        n_checks++;
        if (bus.data_out !== model_dout) begin
            n_fail++;
            $display("FAIL %s done data_out: got %h required %h", tag, bus.data_out, model_dout);
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.func3      = 3'b000;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ack    = 1'b0;
        model_dout     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.data_out, bus.access_fault, bus.mem_req, bus.mem_we, bus.mem_addr,
             bus.mem_be, bus.mem_wdata, bus.busy_wait} !== '0) begin
            n_fail++;
            $display("FAIL reset values: dout=%h flt=%b req=%b we=%b addr=%h be=%b wd=%h busy=%b required all zero",
                     bus.data_out, bus.access_fault, bus.mem_req, bus.mem_we,
                     bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.busy_wait);
        end
        rst = 1'b0;
        // a stray ACK while idle must not start anything
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_req, bus.busy_wait, bus.access_fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle ack: req/busy/fault=%b required 000",
                     {bus.mem_req, bus.busy_wait, bus.access_fault});
        end
    endtask

    task automatic test_basic_load();
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, "lw_0x100");
    endtask

    task automatic test_byte_load_half_store();
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 3, "lb_0x103");
        run_txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 2, "sh_0x202");
    endtask

    task automatic test_faults();
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hFFFF_FFFF, 1, "lw_misaligned");
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'hFFFF_FFFF, 1, "lh_misaligned");
        run_txn(1'b1, 1'b0, 3'b011, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 1, "load_f3_011");
        run_txn(1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'h1, 32'hFFFF_FFFF, 1, "store_f3_100");
        run_txn(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h1, 32'hFFFF_FFFF, 1, "read_and_write");
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0, "lw_timeout");
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, TIMEOUT, "lw_ack_at_limit");
    endtask

    task automatic test_reset_mid_access();
        bus.mem_read   = 1'b1;
        bus.mem_write  = 1'b0;
        bus.func3      = 3'b010;
        bus.address    = 32'h0000_0400;
        bus.mem_rdata  = 32'h1111_2222;
        bus.mem_ack    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_req, bus.busy_wait} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid pre: req/busy=%b required 11", {bus.mem_req, bus.busy_wait});
        end
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b0;
        model_dout = 32'h0;
        n_checks++;
        if ({bus.mem_req, bus.busy_wait, bus.access_fault, bus.data_out} !== 35'h0) begin
            n_fail++;
            $display("FAIL rst_mid post: req=%b busy=%b fault=%b dout=%h required all zero",
                     bus.mem_req, bus.busy_wait, bus.access_fault, bus.data_out);
        end
        // full-length wait shows the counter restarted from zero
        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h7654_3210, 32'h0, TIMEOUT, "sw_after_rst");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_005A, 32'h0, 1, "sb_0x11");
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'h0, 32'h0000_5A00, 1, "lbu_0x11");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] addr;
        int          sel;
        logic        rd;
        logic        wr;
        for (int i = 0; i < 40; i++) begin
            sel  = int'($urandom_range(0, 9));
            rd   = (sel <= 5);
            wr   = (sel == 0) || (sel >= 6);
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_txn(rd, wr, f3, addr, $urandom, $urandom, int'($urandom_range(0, TIMEOUT)), "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_load();
        test_byte_load_half_store();
        test_faults();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
